// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder built from per-bit full-adder cells.
// {c_out, sum} = a + b + cin, visible one clock after in_valid is sampled.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVERFLOW_EN.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef FULL_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p            = a[i] ^ b[i];
        assign sum_c[i]     = p ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & p);
    end

    // ---- stage p0: output registers ----
    logic [WIDTH-1:0] sum_p0;
    logic             c_out_p0;
    logic             vld_p0;

    // Capture the ripple result on accepted inputs; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p0   <= '0;
            c_out_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                sum_p0   <= sum_c;
                c_out_p0 <= carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1 carry[0] is cin, giving c_1 ^ cin.
    logic ovf_c;
    logic ovf_p0;

    assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];

    // Overflow flag tracks the sum register: reset to 0, load on accept, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_p0 <= 1'b0;
        end else if (in_valid) begin
            ovf_p0 <= ovf_c;
        end
    end

    assign overflow = ovf_p0;
`endif

    assign sum       = sum_p0;
    assign c_out     = c_out_p0;
    assign out_valid = vld_p0;

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder: a WIDTH=1 and a WIDTH=8 instance share control
// stimulus. A per-cycle reference of the registered outputs is compared every
// cycle, and a scoreboard queue matches each out_valid pulse to its operands.
`timescale 1ns/1ps
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a8, b8;
    logic       cin;

    logic [7:0] sum8;
    logic       c_out8, vld8;
    logic [0:0] sum1;
    logic       c_out1, vld1;
`ifdef FULL_ADDER_OVERFLOW_EN
    logic       ovf8, ovf1;
`endif

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a8[0:0]), .b(b8[0:0]), .cin(cin),
        .sum(sum1), .c_out(c_out1),
`ifdef FULL_ADDER_OVERFLOW_EN
        .overflow(ovf1),
`endif
        .out_valid(vld1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a8), .b(b8), .cin(cin),
        .sum(sum8), .c_out(c_out8),
`ifdef FULL_ADDER_OVERFLOW_EN
        .overflow(ovf8),
`endif
        .out_valid(vld8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference state of the registered outputs: {ovf, c_out, sum}
    logic [9:0] ref8;
    logic [2:0] ref1;
    logic       ref_vld;
    logic       mon_en = 1'b0;

    // Scoreboard: expected results of accepted inputs, in order.
    logic [9:0] q8[$];
    logic [2:0] q1[$];

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] full;
        logic [7:0] lo;
        full = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        lo   = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, ci};
        return {full[8] ^ lo[7], full[8:0]};
    endfunction

    function automatic logic [2:0] model1(input logic x, input logic y, input logic ci);
        logic [1:0] full;
        full = {1'b0, x} + {1'b0, y} + {1'b0, ci};
        return {full[1] ^ ci, full};
    endfunction

    // Drive one cycle of stimulus, then advance the reference past the edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [9:0] e8;
        logic [2:0] e1;
        rst      = r;
        in_valid = v;
        a8       = x;
        b8       = y;
        cin      = ci;
        e8 = model8(x, y, ci);
        e1 = model1(x[0], y[0], ci);
        if (!r && v) begin
            q8.push_back(e8);
            q1.push_back(e1);
        end
        @(posedge clk);
        if (r) begin
            ref8 = '0;
            ref1 = '0;
        end else if (v) begin
            ref8 = e8;
            ref1 = e1;
        end
        ref_vld = !r && v;
        #1;
    endtask

    // Compare outputs mid-cycle against the reference and the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [9:0] p8;
            logic [2:0] p1;
            check("w8_valid", {63'd0, vld8}, {63'd0, ref_vld});
            check("w8_state", {55'd0, c_out8, sum8}, {55'd0, ref8[8:0]});
            check("w1_valid", {63'd0, vld1}, {63'd0, ref_vld});
            check("w1_state", {62'd0, c_out1, sum1}, {62'd0, ref1[1:0]});
`ifdef FULL_ADDER_OVERFLOW_EN
            check("w8_ovf_state", {63'd0, ovf8}, {63'd0, ref8[9]});
            check("w1_ovf_state", {63'd0, ovf1}, {63'd0, ref1[2]});
`endif
            if (vld8) begin
                if (q8.size() == 0) begin
                    check("w8_sb_underflow", 64'd1, 64'd0);
                end else begin
                    p8 = q8.pop_front();
                    check("w8_sb", {55'd0, c_out8, sum8}, {55'd0, p8[8:0]});
`ifdef FULL_ADDER_OVERFLOW_EN
                    check("w8_sb_ovf", {63'd0, ovf8}, {63'd0, p8[9]});
`endif
                end
            end
            if (vld1) begin
                if (q1.size() == 0) begin
                    check("w1_sb_underflow", 64'd1, 64'd0);
                end else begin
                    p1 = q1.pop_front();
                    check("w1_sb", {62'd0, c_out1, sum1}, {62'd0, p1[1:0]});
`ifdef FULL_ADDER_OVERFLOW_EN
                    check("w1_sb_ovf", {63'd0, ovf1}, {63'd0, p1[2]});
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] combo;
        // Reset for two cycles, then verify the reset state every cycle on.
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // All eight 1-bit combinations {a,b,cin} = 000..111.
        for (int i = 0; i < 8; i++) begin
            combo = i[2:0];
            cyc(1'b0, 1'b1, {7'd0, combo[2]}, {7'd0, combo[1]}, combo[0]);
        end

        // Reset wins over in_valid; then the same operands load once released.
        cyc(1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        check("rst_sum1", {63'd0, sum1}, 64'd0);
        cyc(1'b0, 1'b1, 8'h01, 8'h01, 1'b1);

        // Hold: load 1+0+0, then three idle cycles with different operands.
        cyc(1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h01, 8'h01, 1'b1);

        // 8-bit carry ripple and overflow corners.
        cyc(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0);
        cyc(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Back-to-back random operands.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Directed spot checks of the 8-bit corners against fixed values.
        check("c8_FF_00_1", {54'd0, model8(8'hFF, 8'h00, 1'b1)}, {54'd0, 10'h100});
        check("c8_A5_5A_0", {54'd0, model8(8'hA5, 8'h5A, 1'b0)}, {54'd0, 10'h0FF});

        @(negedge clk);
        mon_en = 1'b0;
        check("w8_sb_drained", 64'(q8.size()), 64'd0);
        check("w1_sb_drained", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
